// File: rtl/data_mem_resp.sv
// Word-organised data RAM responder: single outstanding request, programmable wait states, one-cycle ack.
// Optional per-byte write strobes are enabled by defining DMEM_BYTE_STROBE_EN.
`timescale 1ns/1ps
module data_mem_resp #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  be,
`endif
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
    localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [3:0]         cnt_r, cnt_nxt_s;
    logic               accept_s;
    logic               we_r, fault_r;
    logic [31:0]        addr_r, wdata_r;
    logic [3:0]         be_r;
    logic               cur_we_s, cur_fault_s;
    logic [IDX_W-1:0]   cur_idx_s, wr_idx_s;
    logic [31:0]        rdata_nxt_s;
    logic               ready_r, ack_r, err_r;
    logic [31:0]        rdata_r;
    logic [31:0]        mem_r [DEPTH_WORDS];

    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) ||
               ({1'b0, a} < {1'b0, BASE_ADDR}) ||
               ({1'b0, a} >= END_ADDR);
    endfunction

    // Word index from the 32-bit unsigned byte offset; only meaningful when the address is not faulted.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE_ADDR) >> 2;
        return off[IDX_W-1:0];
    endfunction

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = WAIT_LD;
                    state_nxt_s = (WAIT_LD == 4'd0) ? RESP : WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Response payload; with zero wait states RESP is entered straight from IDLE, so use live inputs there.
    always_comb begin
        cur_we_s    = we_r;
        cur_fault_s = fault_r;
        cur_idx_s   = word_idx(addr_r);
        if (state_r == IDLE) begin
            cur_we_s    = we;
            cur_fault_s = addr_fault(addr);
            cur_idx_s   = word_idx(addr);
        end else begin
            cur_we_s    = we_r;
        end
        if (cur_fault_s || cur_we_s) begin
            rdata_nxt_s = 32'h0000_0000;
        end else begin
            rdata_nxt_s = mem_r[cur_idx_s];
        end
    end

    assign wr_idx_s = word_idx(addr_r);

    // FSM state, request capture and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            fault_r <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'h0;
            ready_r <= 1'b1;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            ack_r   <= (state_nxt_s == RESP);
            if (accept_s) begin
                we_r    <= we;
                fault_r <= addr_fault(addr);
                addr_r  <= addr;
                wdata_r <= wdata;
`ifdef DMEM_BYTE_STROBE_EN
                be_r    <= be;
`else
                be_r    <= 4'hF;
`endif
            end
            if (state_nxt_s == RESP) begin
                rdata_r <= rdata_nxt_s;
                err_r   <= cur_fault_s;
            end
        end
    end

    // Array write commits on the edge that ends RESP; a reset during the transaction leaves RESP unreached.
    always_ff @(posedge clk) begin
        if (state_r == RESP && we_r && !fault_r) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[wr_idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign ready = ready_r;
    assign ack   = ack_r;
    assign rdata = rdata_r;
    assign err   = err_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed scenarios plus randomized traffic against an array model.
`timescale 1ns/1ps
module tb_data_mem_resp;

    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        ready, ack, err;
    logic [31:0] rdata;
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
    logic        ready0, ack0, err0;
    logic [31:0] rdata0;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be = 4'hF;
    logic [3:0]  be0 = 4'hF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];

    always #5 clk = ~clk;

    data_mem_resp dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .be(be),
`endif
        .ready(ready), .ack(ack), .rdata(rdata), .err(err)
    );

    data_mem_resp #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DMEM_BYTE_STROBE_EN
        .be(be0),
`endif
        .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    function automatic bit is_fault(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a);
        return (a % 4 != 0) || (ua < longint'(BASE)) || (ua >= longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    // Issue one request on the default instance; report latency, payload and whether ack/ready misbehaved after.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic e, output logic extra);
        int guard;
        lat = -1; rd = 32'h0; e = 1'b0; extra = 1'b0; guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = k; rd = rdata; e = err;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            extra = (ack !== 1'b0) || (ready !== 1'b1);
        end
    endtask

    task automatic test_reset();
        int acks;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ready, ack, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b ack=%b err=%b rdata=%h, want 1 0 0 0", ready, ack, err, rdata);
        end
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack !== 1'b0) acks++;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL idle_no_ack: got %0d acks, want 0", acks);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic e, x;
        run_txn(1'b1, 32'h100103FC, 32'hDEADBEEF, lat, rd, e, x);
        model_mem[255] = 32'hDEADBEEF; model_known[255] = 1'b1;
        n_checks++;
        if (lat !== LAT || e !== 1'b0 || rd !== 32'h0 || x !== 1'b0) begin
            n_fail++;
            $display("FAIL write_top: got lat=%0d err=%b rdata=%h extra=%b, want %0d 0 0 0", lat, e, rd, x, LAT);
        end
        run_txn(1'b0, 32'h100103FC, 32'h0, lat, rd, e, x);
        n_checks++;
        if (lat !== LAT || e !== 1'b0 || rd !== 32'hDEADBEEF || x !== 1'b0) begin
            n_fail++;
            $display("FAIL read_top: got lat=%0d err=%b rdata=%h extra=%b, want %0d 0 deadbeef 0", lat, e, rd, x, LAT);
        end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd; logic e, x;
        run_txn(1'b1, BASE, 32'hCAFEF00D, lat, rd, e, x);
        model_mem[0] = 32'hCAFEF00D; model_known[0] = 1'b1;
        run_txn(1'b0, 32'h10010002, 32'h0, lat, rd, e, x);
        n_checks++;
        if (lat !== LAT || e !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned: got lat=%0d err=%b rdata=%h, want %0d 1 0", lat, e, rd, LAT);
        end
        run_txn(1'b1, 32'h10010400, 32'h0BADBAD0, lat, rd, e, x);
        n_checks++;
        if (lat !== LAT || e !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL above_range: got lat=%0d err=%b rdata=%h, want %0d 1 0", lat, e, rd, LAT);
        end
        run_txn(1'b1, 32'h1000FFFC, 32'h0BADBAD1, lat, rd, e, x);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++;
            $display("FAIL below_range: got err=%b, want 1", e);
        end
        run_txn(1'b0, BASE, 32'h0, lat, rd, e, x);
        n_checks++;
        if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL base_unchanged: got err=%b rdata=%h, want 0 cafef00d", e, rd);
        end
    endtask

    task automatic test_busy();
        int acks; int lat; logic [31:0] rd; logic e, x;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h100103FC;
        @(posedge clk);
        #1 req = 1'b0;
        acks = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
            if (k == 1) begin
                req = 1'b1; we = 1'b1; wdata = 32'h0;
            end else begin
                req = 1'b0;
            end
        end
        n_checks++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL busy_acks: got %0d acks, want 1", acks);
        end
        run_txn(1'b0, 32'h100103FC, 32'h0, lat, rd, e, x);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL busy_ignored: got rdata=%h, want deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, acks;
        first = -1; second = -1; acks = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = BASE;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                acks++;
                if (first < 0) first = k; else second = k;
            end
        end
        req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks !== 2 || first !== LAT || second !== 2 * LAT + 1) begin
            n_fail++;
            $display("FAIL held_req: got acks=%0d at %0d,%0d, want 2 at %0d,%0d", acks, first, second, LAT, 2 * LAT + 1);
        end
    endtask

    task automatic test_latency0();
        int lat;
        logic [31:0] rd;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            req0 = 1'b1; we0 = (t == 0); addr0 = 32'h10010020; wdata0 = 32'h55AA55AA;
            @(posedge clk);
            #1 req0 = 1'b0;
            lat = -1; rd = 32'h0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (ack0 === 1'b1) begin
                    lat = k; rd = rdata0;
                    break;
                end
            end
            n_checks++;
            if (lat !== 1 || rd !== ((t == 0) ? 32'h0 : 32'h55AA55AA)) begin
                n_fail++;
                $display("FAIL lat0_txn%0d: got lat=%0d rdata=%h, want 1", t, lat, rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, acks; logic [31:0] rd; logic e, x;
        run_txn(1'b1, 32'h10010010, 32'h0, lat, rd, e, x);
        model_mem[4] = 32'h0; model_known[4] = 1'b1;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10010010; wdata = 32'h12345678;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort: got ready=%b ack=%b, want 1 0", ready, ack);
        end
        acks = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL abort_no_ack: got %0d acks, want 0", acks);
        end
        run_txn(1'b0, 32'h10010010, 32'h0, lat, rd, e, x);
        n_checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_write: got rdata=%h err=%b, want 0 0", rd, e);
        end
    endtask

    task automatic test_random();
        int lat, sel, i; logic [31:0] rd, a, d, exp_rd; logic e, x, w, exp_e;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (sel == 0)      a = BASE + 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (sel == 1) a = BASE + 32'd1024 + 32'($urandom_range(0, 64)) * 32'd4;
            else if (sel == 2) a = BASE - 32'd4 * 32'($urandom_range(1, 64));
            else               a = BASE + 32'd4 * 32'($urandom_range(0, 15));
            run_txn(w, a, d, lat, rd, e, x);
            exp_e = is_fault(a);
            exp_rd = 32'h0;
            if (!exp_e) begin
                i = idx_of(a);
                if (w) begin
                    model_mem[i] = d; model_known[i] = 1'b1;
                end else if (model_known[i]) begin
                    exp_rd = model_mem[i];
                end else begin
                    exp_rd = rd;
                end
            end
            n_checks++;
            if (lat !== LAT || e !== exp_e || rd !== exp_rd || x !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d we=%b addr=%h: got lat=%0d err=%b rdata=%h extra=%b, want %0d %b %h 0",
                         n, w, a, lat, e, rd, x, LAT, exp_e, exp_rd);
            end
        end
    endtask

`ifdef DMEM_BYTE_STROBE_EN
    task automatic test_byte_strobe();
        int lat; logic [31:0] rd; logic e, x;
        be = 4'hF;
        run_txn(1'b1, 32'h10010100, 32'h11223344, lat, rd, e, x);
        be = 4'b0101;
        run_txn(1'b1, 32'h10010100, 32'hAABBCCDD, lat, rd, e, x);
        be = 4'b0000;
        run_txn(1'b1, 32'h10010100, 32'hFFFFFFFF, lat, rd, e, x);
        n_checks++;
        if (e !== 1'b0 || lat !== LAT) begin
            n_fail++;
            $display("FAIL be_zero: got err=%b lat=%0d, want 0 %0d", e, lat, LAT);
        end
        run_txn(1'b0, 32'h10010100, 32'h0, lat, rd, e, x);
        be = 4'hF;
        n_checks++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL byte_strobe: got rdata=%h, want 11bb33dd", rd);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        test_reset();
        test_write_read();
        test_faults();
        test_busy();
        test_back_to_back();
        test_latency0();
        test_reset_mid();
        test_random();
`ifdef DMEM_BYTE_STROBE_EN
        test_byte_strobe();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
